// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - ID-stage per-register pending scoreboard (int + FP files), stall/issue generation
// Optional macro ID_SCOREBOARD_BYPASS_EN: a fixed-latency result one cycle from done does not cause a RAW stall.
module id_scoreboard #(
    parameter  int NREGS   = 32,
    parameter  int MAX_LAT = 4,
    parameter  int MAX_VAR = 2,
    localparam int AW      = $clog2(NREGS),
    localparam int CW      = $clog2(MAX_LAT + 1),
    localparam int VW      = $clog2(MAX_VAR + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic          id_rs1_en,
    input  logic          id_rs2_en,
    input  logic [AW-1:0] id_fs1,
    input  logic [AW-1:0] id_fs2,
    input  logic [AW-1:0] id_fs3,
    input  logic          id_fs1_en,
    input  logic          id_fs2_en,
    input  logic          id_fs3_en,
    input  logic [AW-1:0] id_rd,
    input  logic          id_rd_en,
    input  logic          id_rd_fp,
    input  logic [CW-1:0] id_lat,
    input  logic          id_var,
    input  logic          ex_stall,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_rd,
    input  logic          wb_fp,
    output logic          stall,
    output logic          issue,
    output logic [VW-1:0] var_cnt,
    output logic          err
);

    logic [CW-1:0]    int_cnt [NREGS];
    logic [CW-1:0]    fp_cnt  [NREGS];
    logic [NREGS-1:0] int_vp, fp_vp;
    logic [NREGS-1:0] int_vp_nxt, fp_vp_nxt;
    logic [NREGS-1:0] int_pend, fp_pend, int_raw_pend, fp_raw_pend;

    logic          raw, waw, var_full;
    logic          rd_live, fix_load, var_set, wb_hit;
    logic [CW-1:0] lat_eff;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            int_pend[r] = (int_cnt[r] != '0) | int_vp[r];
            fp_pend[r]  = (fp_cnt[r] != '0) | fp_vp[r];
`ifdef ID_SCOREBOARD_BYPASS_EN
            // cnt==1 while the pipe moves means the result is forwarded next cycle
            int_raw_pend[r] = ((int_cnt[r] != '0) & ~((int_cnt[r] == CW'(1)) & ~ex_stall)) | int_vp[r];
            fp_raw_pend[r]  = ((fp_cnt[r] != '0) & ~((fp_cnt[r] == CW'(1)) & ~ex_stall)) | fp_vp[r];
`else
            int_raw_pend[r] = int_pend[r];
            fp_raw_pend[r]  = fp_pend[r];
`endif
        end
        int_pend[0]     = 1'b0;
        int_raw_pend[0] = 1'b0;
    end

    assign raw = (id_rs1_en & int_raw_pend[id_rs1]) |
                 (id_rs2_en & int_raw_pend[id_rs2]) |
                 (id_fs1_en & fp_raw_pend[id_fs1])  |
                 (id_fs2_en & fp_raw_pend[id_fs2])  |
                 (id_fs3_en & fp_raw_pend[id_fs3]);

    assign waw      = id_rd_en & (id_rd_fp ? fp_pend[id_rd] : int_pend[id_rd]);
    assign var_full = id_var & id_rd_en & (var_cnt == VW'(MAX_VAR));
    assign stall    = id_valid & (raw | waw | var_full);
    assign issue    = id_valid & ~stall & ~ex_stall;

    assign rd_live  = id_rd_en & (id_rd_fp | (id_rd != '0));
    assign fix_load = issue & rd_live & ~id_var;
    assign var_set  = issue & rd_live & id_var;
    assign lat_eff  = (id_lat == '0) ? CW'(1) : id_lat;
    assign wb_hit   = wb_valid & (wb_fp ? fp_vp[wb_rd] : int_vp[wb_rd]);

    // Clear from writeback first so a colliding set on the same register wins
    always_comb begin
        int_vp_nxt = int_vp;
        fp_vp_nxt  = fp_vp;
        if (wb_valid && !wb_fp) int_vp_nxt[wb_rd] = 1'b0;
        if (wb_valid && wb_fp)  fp_vp_nxt[wb_rd]  = 1'b0;
        if (var_set && !id_rd_fp) int_vp_nxt[id_rd] = 1'b1;
        if (var_set && id_rd_fp)  fp_vp_nxt[id_rd]  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                int_cnt[r] <= '0;
                fp_cnt[r]  <= '0;
            end
            int_vp  <= '0;
            fp_vp   <= '0;
            var_cnt <= '0;
            err     <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (fix_load && !id_rd_fp && id_rd == AW'(r))
                    int_cnt[r] <= lat_eff;
                else if (!ex_stall && int_cnt[r] != '0)
                    int_cnt[r] <= int_cnt[r] - 1'b1;
                if (fix_load && id_rd_fp && id_rd == AW'(r))
                    fp_cnt[r] <= lat_eff;
                else if (!ex_stall && fp_cnt[r] != '0)
                    fp_cnt[r] <= fp_cnt[r] - 1'b1;
            end
            int_vp  <= int_vp_nxt;
            fp_vp   <= fp_vp_nxt;
            var_cnt <= var_cnt + VW'(var_set) - VW'(wb_hit);
            // A writeback to a non-pending register also covers the illegal same-register collision
            if (wb_valid && !wb_hit)
                err <= 1'b1;
        end
    end

endmodule
